// File: rtl/sfp_status_pkg.sv
// Shared types and constants for the SFP link status block.
package sfp_status_pkg;

   typedef enum logic [1:0] {
      CH_DOWN  = 2'd0,
      CH_TRAIN = 2'd1,
      CH_UP    = 2'd2,
      CH_FAULT = 2'd3
   } chan_state_t;

   localparam int unsigned DROP_W = 16;

   // Bits needed to hold values 0..max_val (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sfp_chan_status.sv
// One SFP channel: link FSM, activity hold, fault timer, drop counter, LED mux.
module sfp_chan_status
   import sfp_status_pkg::*;
#(
   parameter int unsigned DEBOUNCE_TICKS = 200,
   parameter int unsigned ACT_HOLD_TICKS = 20,
   parameter int unsigned FAULT_TICKS    = 500
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              blink_ph,
   input  logic              heart_ph,
   input  logic              link_up,
   input  logic              act,
   input  logic              err,
   input  logic              cnt_clr,
   output logic              led,
   output logic              chan_up,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int unsigned TW = cnt_width(DEBOUNCE_TICKS - 1);
   localparam int unsigned HW = cnt_width(ACT_HOLD_TICKS);
   localparam int unsigned FW = cnt_width(FAULT_TICKS);

   localparam logic [TW-1:0]     TRAIN_LAST = TW'(DEBOUNCE_TICKS - 1);
   localparam logic [TW-1:0]     TRAIN_ONE  = TW'(1);
   localparam logic [HW-1:0]     HOLD_LOAD  = HW'(ACT_HOLD_TICKS);
   localparam logic [HW-1:0]     HOLD_ONE   = HW'(1);
   localparam logic [FW-1:0]     FAULT_LOAD = FW'(FAULT_TICKS);
   localparam logic [FW-1:0]     FAULT_ONE  = FW'(1);
   localparam logic [DROP_W-1:0] DROP_ONE   = DROP_W'(1);

   chan_state_t       state;
   logic [TW-1:0]     train_cnt;
   logic [HW-1:0]     hold_cnt;
   logic [FW-1:0]     fault_cnt;
   logic [DROP_W-1:0] drop_q;
   logic              drop_evt;
   logic              led_next;

   assign drop_evt = !link_up && ((state == CH_UP) || (state == CH_FAULT));
   assign drop_cnt = drop_q;

   // LED pattern for the current state and phases.
   always_comb begin
      led_next = 1'b0;
      case (state)
         CH_DOWN:  led_next = 1'b0;
         CH_TRAIN: led_next = blink_ph;
         CH_UP:    led_next = (hold_cnt != '0) ? ~blink_ph : 1'b1;
         CH_FAULT: led_next = heart_ph & blink_ph;
         default:  led_next = 1'b0;
      endcase
   end

   // Channel FSM with debounce/fault timers; LED and chan_up registered from current state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= CH_DOWN;
         train_cnt <= '0;
         fault_cnt <= '0;
         led       <= 1'b0;
         chan_up   <= 1'b0;
      end else begin
         led     <= led_next;
         chan_up <= (state == CH_UP) || (state == CH_FAULT);
         case (state)
            CH_DOWN: begin
               if (link_up) begin
                  state     <= CH_TRAIN;
                  train_cnt <= '0;
               end
            end
            CH_TRAIN: begin
               if (!link_up) begin
                  state <= CH_DOWN;
               end else if (tick) begin
                  if (train_cnt == TRAIN_LAST) state <= CH_UP;
                  else                         train_cnt <= train_cnt + TRAIN_ONE;
               end
            end
            CH_UP: begin
               if (!link_up) begin
                  state <= CH_DOWN;
               end else if (err) begin
                  state     <= CH_FAULT;
                  fault_cnt <= FAULT_LOAD;
               end
            end
            CH_FAULT: begin
               if (!link_up) begin
                  state     <= CH_DOWN;
                  fault_cnt <= '0;
               end else if (err) begin
                  fault_cnt <= FAULT_LOAD;
               end else if (tick) begin
                  if (FAULT_ONE >= fault_cnt) begin
                     state     <= CH_UP;
                     fault_cnt <= '0;
                  end else begin
                     fault_cnt <= fault_cnt - FAULT_ONE;
                  end
               end
            end
            default: state <= CH_DOWN;
         endcase
      end
   end

   // Activity hold: reload on any act pulse, otherwise count down once per tick.
   always_ff @(posedge clk) begin
      if (rst)                          hold_cnt <= '0;
      else if (act)                     hold_cnt <= HOLD_LOAD;
      else if (tick && hold_cnt != '0)  hold_cnt <= hold_cnt - HOLD_ONE;
   end

   // Saturating drop counter; a clear coinciding with a drop leaves exactly one.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_q <= '0;
      end else if (drop_evt) begin
         if (cnt_clr)          drop_q <= DROP_ONE;
         else if (drop_q != '1) drop_q <= drop_q + DROP_ONE;
      end else if (cnt_clr) begin
         drop_q <= '0;
      end
   end

endmodule

// File: rtl/sfp_link_status.sv
// SFP link status top: shared tick prescaler and blink/heartbeat phases, per-channel status.
module sfp_link_status
   import sfp_status_pkg::*;
#(
   parameter int unsigned SFP_COUNT       = 2,
   parameter int unsigned LED_COUNT       = 4,
   parameter int unsigned TICK_DIV        = 100000,
   parameter int unsigned DEBOUNCE_TICKS  = 200,
   parameter int unsigned BLINK_TICKS     = 50,
   parameter int unsigned ACT_HOLD_TICKS  = 20,
   parameter int unsigned FAULT_TICKS     = 500,
   parameter int unsigned HEARTBEAT_TICKS = 500
) (
   input  logic                          sysclk_100m,
   input  logic                          sys_reset,
   input  logic [SFP_COUNT-1:0]          link_up,
   input  logic [SFP_COUNT-1:0]          act,
   input  logic [SFP_COUNT-1:0]          err,
   input  logic                          cnt_clr,
   output logic [LED_COUNT-1:0]          sleds,
   output logic [SFP_COUNT-1:0]          chan_up,
   output logic [DROP_W*SFP_COUNT-1:0]   drop_cnt
);

   localparam int unsigned DW = cnt_width(TICK_DIV - 1);
   localparam int unsigned BW = cnt_width(BLINK_TICKS - 1);
   localparam int unsigned HW = cnt_width(HEARTBEAT_TICKS - 1);

   localparam logic [DW-1:0] DIV_LAST   = DW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DIV_ONE    = DW'(1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
   localparam logic [BW-1:0] BLINK_ONE  = BW'(1);
   localparam logic [HW-1:0] HEART_LAST = HW'(HEARTBEAT_TICKS - 1);
   localparam logic [HW-1:0] HEART_ONE  = HW'(1);

   logic [DW-1:0]        div_cnt;
   logic [BW-1:0]        blink_cnt;
   logic [HW-1:0]        heart_cnt;
   logic                 blink_ph;
   logic                 heart_ph;
   logic                 tick;
   logic [SFP_COUNT-1:0] chan_led;

   assign tick = (div_cnt == DIV_LAST);

   // Free-running prescaler 0..TICK_DIV-1.
   always_ff @(posedge sysclk_100m) begin
      if (sys_reset)  div_cnt <= '0;
      else if (tick)  div_cnt <= '0;
      else            div_cnt <= div_cnt + DIV_ONE;
   end

   // Blink and heartbeat phases, each toggling after its own number of ticks.
   always_ff @(posedge sysclk_100m) begin
      if (sys_reset) begin
         blink_cnt <= '0;
         heart_cnt <= '0;
         blink_ph  <= 1'b0;
         heart_ph  <= 1'b0;
      end else if (tick) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
         end else begin
            blink_cnt <= blink_cnt + BLINK_ONE;
         end
         if (heart_cnt == HEART_LAST) begin
            heart_cnt <= '0;
            heart_ph  <= ~heart_ph;
         end else begin
            heart_cnt <= heart_cnt + HEART_ONE;
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < SFP_COUNT; g++) begin : g_chan
         sfp_chan_status #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .ACT_HOLD_TICKS (ACT_HOLD_TICKS),
            .FAULT_TICKS    (FAULT_TICKS)
         ) u_chan (
            .clk      (sysclk_100m),
            .rst      (sys_reset),
            .tick     (tick),
            .blink_ph (blink_ph),
            .heart_ph (heart_ph),
            .link_up  (link_up[g]),
            .act      (act[g]),
            .err      (err[g]),
            .cnt_clr  (cnt_clr),
            .led      (chan_led[g]),
            .chan_up  (chan_up[g]),
            .drop_cnt (drop_cnt[DROP_W*g +: DROP_W])
         );
      end
   endgenerate

   // LED map: channel LEDs low, heartbeat on the top LED, the rest dark.
   always_comb begin
      sleds = '0;
      for (int unsigned i = 0; i < SFP_COUNT; i++) sleds[i] = chan_led[i];
      sleds[LED_COUNT-1] = heart_ph;
   end

endmodule
